// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial receiver/transmitter pair: the framer
// state encoding, parity-mode constants and a parity check helper.
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // data_xor is the XOR of all data bits together with the received parity
  // bit; even parity expects 0, odd parity expects 1.
  function automatic logic parity_fail(input logic [1:0] mode, input logic data_xor);
    logic fail;
    fail = 1'b0;
    if (mode == 2'(PARITY_EVEN)) begin
      fail = data_xor;
    end else if (mode == 2'(PARITY_ODD)) begin
      fail = ~data_xor;
    end
    return fail;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Multi-flop synchroniser for a single asynchronous input.
// Ports:
//   clk  - sampling clock (rising edge)
//   rst  - asynchronous active-high reset, loads RESET_VAL into every flop
//   d    - asynchronous input
//   q    - synchronised output, STAGES clocks behind d
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] flops;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flops <= {STAGES{RESET_VAL}};
    end else begin
      flops <= {flops[STAGES-2:0], d};
    end
  end

  assign q = flops[STAGES-1];

endmodule

// File: rtl/serial_rx_framer.sv
// ---------------------------------------------------------------------------
// serial_rx_framer
// Oversampling asynchronous serial receiver: start-bit validation, LSB-first
// data capture, optional parity, stop-bit check and a held character-valid
// flag with consumer handshake.
// Ports:
//   clk, rst     - clock (rising edge) and asynchronous active-high reset
//   sample_tick  - one-clk strobe, OVERSAMPLE strobes per bit period
//   serialIn     - asynchronous serial line, idle high
//   recvStart    - high from validated start bit to the stop-bit sample
//   data_out     - last received character
//   charRec      - character valid, held until data_ack
//   data_ack     - consumer acknowledge, clears charRec
//   frame_err    - stop bit was sampled low
//   parity_err   - parity check failed (always 0 without parity)
//   overrun      - a character was overwritten before being acknowledged
// ---------------------------------------------------------------------------
module serial_rx_framer
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 serialIn,
  output logic                 recvStart,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 charRec,
  input  logic                 data_ack,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int CNT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);

  rx_state_t state, state_next;

  logic                 line;
  logic                 line_prev;
  logic [TICK_W-1:0]    tick_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic                 sample_point;
  logic                 start_ok;
  logic                 complete;
  logic                 par_fail;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serialIn),
    .q   (line)
  );

  // The start bit is sampled half a bit in; every later bit one full bit
  // after the previous sample, so all samples land mid-bit.
  always_comb begin
    sample_point = 1'b0;
    if (sample_tick) begin
      case (state)
        START:              sample_point = (tick_cnt == HALF_LAST);
        DATA, PARITY, STOP: sample_point = (tick_cnt == FULL_LAST);
        default:            sample_point = 1'b0;
      endcase
    end
  end

  assign start_ok = (state == START) && sample_point && !line;
  assign complete = (state == STOP) && sample_point;
  assign par_fail = parity_fail(2'(PARITY_MODE), (^shift_reg) ^ parity_bit);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // Edge-triggered so a line stuck low cannot start a second frame.
        if (line_prev && !line) state_next = START;
      end
      START: begin
        if (sample_point) state_next = line ? IDLE : DATA;
      end
      DATA: begin
        if (sample_point && (bit_cnt == LAST_BIT)) begin
          state_next = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample_point) state_next = STOP;
      end
      STOP: begin
        if (sample_point) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bit timing and character assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_prev  <= 1'b1;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      line_prev <= line;
      if (state == IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (sample_tick) begin
        tick_cnt <= sample_point ? '0 : tick_cnt + TICK_W'(1);
      end
      if ((state == DATA) && sample_point) begin
        shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end
      if ((state == PARITY) && sample_point) begin
        parity_bit <= line;
      end
    end
  end

  // Output register and handshake; a completing character takes priority
  // over an acknowledge arriving in the same clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recvStart  <= 1'b0;
      data_out   <= '0;
      charRec    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (start_ok) begin
        recvStart <= 1'b1;
      end else if (complete) begin
        recvStart <= 1'b0;
      end
      if (complete) begin
        data_out   <= shift_reg;
        frame_err  <= ~line;
        parity_err <= par_fail;
        charRec    <= 1'b1;
        overrun    <= charRec && !data_ack;
      end else if (data_ack && charRec) begin
        charRec <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_framer.sv
// ---------------------------------------------------------------------------
// tb_serial_rx_framer
// Bench for serial_rx_framer: one 8N1 instance and one 8E1 instance, frames
// built bit-by-bit from the line format and checked against a character
// level model of the receiver's output register.
// ---------------------------------------------------------------------------
module tb_serial_rx_framer;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int FULL = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0;
  logic line_drv = 1'b1;
  logic ack_drv = 1'b0;
  logic sel_b = 1'b0;

  logic line_a, line_b, data_ack_a, data_ack_b;
  logic rs_a, cr_a, fe_a, pe_a, ov_a;
  logic rs_b, cr_b, fe_b, pe_b, ov_b;
  logic [DB-1:0] do_a, do_b;

  int checks = 0;
  int errors = 0;
  int rs_cnt = 0;

  // Character-level model: index 0 is the 8N1 receiver, 1 the 8E1 receiver.
  logic [DB-1:0] m_data [2];
  logic          m_cr   [2];
  logic          m_fe   [2];
  logic          m_pe   [2];
  logic          m_ov   [2];

  always #5 clk = ~clk;

  assign line_a     = sel_b ? 1'b1 : line_drv;
  assign line_b     = sel_b ? line_drv : 1'b1;
  assign data_ack_a = ack_drv && !sel_b;
  assign data_ack_b = ack_drv && sel_b;

  always @(negedge clk) begin
    if (rs_a) rs_cnt <= rs_cnt + 1;
  end

  serial_rx_framer #(
    .OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY_MODE(0), .SYNC_STAGES(2)
  ) dut_a (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .serialIn(line_a),
    .recvStart(rs_a), .data_out(do_a), .charRec(cr_a), .data_ack(data_ack_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
  );

  serial_rx_framer #(
    .OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY_MODE(1), .SYNC_STAGES(3)
  ) dut_b (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .serialIn(line_b),
    .recvStart(rs_b), .data_out(do_b), .charRec(cr_b), .data_ack(data_ack_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_data[d] = '0; m_cr[d] = 1'b0; m_fe[d] = 1'b0; m_pe[d] = 1'b0; m_ov[d] = 1'b0;
    end
  endtask

  task automatic model_complete(input int d, input logic [DB-1:0] data, input logic pbit,
                                input logic stop, input logic acked);
    m_ov[d]   = m_cr[d] && !acked;
    m_cr[d]   = 1'b1;
    m_data[d] = data;
    m_fe[d]   = !stop;
    m_pe[d]   = (d == 1) ? ((^data) ^ pbit) : 1'b0;
  endtask

  task automatic model_ack(input int d);
    if (m_cr[d]) begin
      m_cr[d] = 1'b0;
      m_ov[d] = 1'b0;
    end
  endtask

  // One oversample period of 8 clocks; the strobe sits at the end so line
  // changes made right after a strobe are synchronised before the next one.
  task automatic tick(input logic ack);
    repeat (7) @(negedge clk);
    sample_tick = 1'b1;
    ack_drv     = ack;
    @(negedge clk);
    sample_tick = 1'b0;
    ack_drv     = 1'b0;
  endtask

  task automatic hold_line(input logic v, input int n);
    line_drv = v;
    repeat (n) tick(1'b0);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack_drv = 1'b1;
    @(negedge clk);
    ack_drv = 1'b0;
    model_ack(sel_b ? 1 : 0);
  endtask

  // Drives start, data (LSB first), parity on the 8E1 line, and stop, each
  // bit OS strobes long. The stop bit is sampled OS/2 + OS*(bits-1) strobes
  // after the falling edge; ack_tick equal to that asserts data_ack in the
  // completion clock. max_ticks truncates the frame.
  task automatic send_frame(input logic [DB-1:0] data, input logic pbit, input logic stop,
                            input int ack_tick, input int max_ticks);
    logic bits[$];
    int t;
    int stop_tick;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(data[i]);
    if (sel_b) bits.push_back(pbit);
    bits.push_back(stop);
    stop_tick = OS / 2 + OS * (bits.size() - 1);
    t = 0;
    for (int i = 0; i < bits.size(); i++) begin
      if (t < max_ticks) begin
        line_drv = bits[i];
        for (int j = 0; j < OS; j++) begin
          if (t < max_ticks) begin
            t++;
            tick(t == ack_tick);
          end
        end
      end
    end
    if (t >= stop_tick) model_complete(sel_b ? 1 : 0, data, pbit, stop, ack_tick == stop_tick);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rs_a, do_a, cr_a, fe_a, pe_a, ov_a} !== '0) begin
      $display("[TB] FAIL reset_a got %b expected 0", {rs_a, do_a, cr_a, fe_a, pe_a, ov_a});
      errors++;
    end
    checks++;
    if ({rs_b, do_b, cr_b, fe_b, pe_b, ov_b} !== '0) begin
      $display("[TB] FAIL reset_b got %b expected 0", {rs_b, do_b, cr_b, fe_b, pe_b, ov_b});
      errors++;
    end
    rst = 1'b0;
    hold_line(1'b1, 4);
    checks++;
    if ({rs_a, cr_a} !== 2'b00) begin
      $display("[TB] FAIL post_reset_idle got %b expected 00", {rs_a, cr_a});
      errors++;
    end
  endtask

  task automatic test_basic();
    int rs0, rs_len;
    sel_b = 1'b0;
    rs0 = rs_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 0, FULL);
    hold_line(1'b1, 4);
    rs_len = rs_cnt - rs0;
    checks++;
    if (do_a !== 8'hA5) begin
      $display("[TB] FAIL basic_data got %h expected a5", do_a); errors++;
    end
    checks++;
    if ({cr_a, fe_a, pe_a, ov_a, rs_a} !== 5'b10000) begin
      $display("[TB] FAIL basic_flags got %b expected 10000", {cr_a, fe_a, pe_a, ov_a, rs_a});
      errors++;
    end
    // Start validated half a bit in, stop sampled mid-bit: about 9 bit times.
    checks++;
    if (rs_len < (OS * 8 * 17) / 2 || rs_len > OS * 8 * 10) begin
      $display("[TB] FAIL basic_recvstart_len got %0d clocks expected about %0d", rs_len, OS * 8 * 9);
      errors++;
    end
  endtask

  task automatic test_glitch();
    int rs0;
    sel_b = 1'b0;
    ack_pulse();
    checks++;
    if ({cr_a, ov_a} !== 2'b00) begin
      $display("[TB] FAIL ack_clear got %b expected 00", {cr_a, ov_a}); errors++;
    end
    rs0 = rs_cnt;
    hold_line(1'b0, 4);
    hold_line(1'b1, 40);
    checks++;
    if (rs_cnt != rs0) begin
      $display("[TB] FAIL glitch_recvstart got %0d high clocks expected 0", rs_cnt - rs0);
      errors++;
    end
    checks++;
    if (cr_a !== 1'b0) begin
      $display("[TB] FAIL glitch_charrec got %b expected 0", cr_a); errors++;
    end
  endtask

  task automatic test_parity();
    sel_b = 1'b1;
    hold_line(1'b1, 2);
    send_frame(8'h07, 1'b0, 1'b1, 0, FULL);
    hold_line(1'b1, 4);
    checks++;
    if ({do_b, pe_b, cr_b, fe_b} !== {8'h07, 3'b110}) begin
      $display("[TB] FAIL parity_bad got %h/%b expected 07/110", do_b, {pe_b, cr_b, fe_b});
      errors++;
    end
    send_frame(8'h07, 1'b1, 1'b1, 0, FULL);
    hold_line(1'b1, 4);
    checks++;
    if ({do_b, cr_b, fe_b, pe_b, ov_b} !== {m_data[1], m_cr[1], m_fe[1], m_pe[1], m_ov[1]}) begin
      $display("[TB] FAIL parity_good got %h/%b expected %h/%b", do_b, {cr_b, fe_b, pe_b, ov_b},
               m_data[1], {m_cr[1], m_fe[1], m_pe[1], m_ov[1]});
      errors++;
    end
    sel_b = 1'b0;
  endtask

  task automatic test_frame_err();
    int rs0;
    sel_b = 1'b0;
    ack_pulse();
    send_frame(8'h3C, 1'b0, 1'b0, 0, FULL);
    rs0 = rs_cnt;
    hold_line(1'b0, 48);
    checks++;
    if ({do_a, fe_a, cr_a, ov_a} !== {8'h3C, 3'b110}) begin
      $display("[TB] FAIL frame_err got %h/%b expected 3c/110", do_a, {fe_a, cr_a, ov_a});
      errors++;
    end
    checks++;
    if (rs_cnt != rs0) begin
      $display("[TB] FAIL held_low_retrigger got %0d high clocks expected 0", rs_cnt - rs0);
      errors++;
    end
    hold_line(1'b1, 20);
    ack_pulse();
    send_frame(8'h96, 1'b0, 1'b1, 0, FULL);
    hold_line(1'b1, 4);
    checks++;
    if ({do_a, fe_a, cr_a, ov_a} !== {8'h96, 3'b010}) begin
      $display("[TB] FAIL after_frame_err got %h/%b expected 96/010", do_a, {fe_a, cr_a, ov_a});
      errors++;
    end
  endtask

  task automatic test_overrun();
    sel_b = 1'b0;
    ack_pulse();
    send_frame(8'h11, 1'b0, 1'b1, 0, FULL);
    hold_line(1'b1, 6);
    send_frame(8'h22, 1'b0, 1'b1, 0, FULL);
    hold_line(1'b1, 4);
    checks++;
    if ({do_a, cr_a, ov_a} !== {8'h22, 2'b11}) begin
      $display("[TB] FAIL overrun got %h/%b expected 22/11", do_a, {cr_a, ov_a}); errors++;
    end
    ack_pulse();
    checks++;
    if ({cr_a, ov_a} !== 2'b00) begin
      $display("[TB] FAIL overrun_ack got %b expected 00", {cr_a, ov_a}); errors++;
    end
    ack_pulse();
    checks++;
    if ({cr_a, ov_a, do_a} !== {2'b00, 8'h22}) begin
      $display("[TB] FAIL idle_ack got %b/%h expected 00/22", {cr_a, ov_a}, do_a); errors++;
    end
  endtask

  task automatic test_back_to_back();
    sel_b = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1, 0, FULL);
    send_frame(8'h44, 1'b0, 1'b1, OS / 2 + OS * (DB + 1), FULL);
    hold_line(1'b1, 4);
    checks++;
    if ({do_a, cr_a, ov_a} !== {8'h44, 2'b10}) begin
      $display("[TB] FAIL ack_with_completion got %h/%b expected 44/10", do_a, {cr_a, ov_a});
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    sel_b = 1'b0;
    send_frame(8'h13, 1'b0, 1'b1, 0, OS * 5 + OS / 2);
    checks++;
    if ({rs_a, cr_a} !== 2'b11) begin
      $display("[TB] FAIL mid_char_state got %b expected 11", {rs_a, cr_a}); errors++;
    end
    line_drv = 1'b1;
    #3 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({rs_a, do_a, cr_a, fe_a, pe_a, ov_a} !== '0) begin
      $display("[TB] FAIL async_reset got %b expected 0", {rs_a, do_a, cr_a, fe_a, pe_a, ov_a});
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    hold_line(1'b1, 20);
    checks++;
    if ({rs_a, cr_a} !== 2'b00) begin
      $display("[TB] FAIL after_reset_idle got %b expected 00", {rs_a, cr_a}); errors++;
    end
    send_frame(8'h5A, 1'b0, 1'b1, 0, FULL);
    hold_line(1'b1, 4);
    checks++;
    if ({do_a, cr_a, fe_a, ov_a} !== {8'h5A, 3'b100}) begin
      $display("[TB] FAIL after_reset_frame got %h/%b expected 5a/100", do_a, {cr_a, fe_a, ov_a});
      errors++;
    end
  endtask

  task automatic test_random();
    logic [DB-1:0] data;
    logic pbit, stop;
    for (int n = 0; n < 16; n++) begin
      sel_b = (n >= 10);
      data  = DB'($urandom);
      pbit  = 1'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) ack_pulse();
      send_frame(data, pbit, stop, 0, FULL);
      hold_line(1'b1, $urandom_range(2, 20));
      checks++;
      if (!sel_b) begin
        if ({do_a, cr_a, fe_a, pe_a, ov_a} !== {m_data[0], m_cr[0], m_fe[0], m_pe[0], m_ov[0]}) begin
          $display("[TB] FAIL random_a_%0d got %h/%b expected %h/%b", n, do_a,
                   {cr_a, fe_a, pe_a, ov_a}, m_data[0], {m_cr[0], m_fe[0], m_pe[0], m_ov[0]});
          errors++;
        end
      end else begin
        if ({do_b, cr_b, fe_b, pe_b, ov_b} !== {m_data[1], m_cr[1], m_fe[1], m_pe[1], m_ov[1]}) begin
          $display("[TB] FAIL random_b_%0d got %h/%b expected %h/%b", n, do_b,
                   {cr_b, fe_b, pe_b, ov_b}, m_data[1], {m_cr[1], m_fe[1], m_pe[1], m_ov[1]});
          errors++;
        end
      end
    end
    sel_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
